// File: rtl/phy_lane_sched.sv
// phy_lane_sched: round-robin scheduler that shares two serial PHY lanes among
// NUM_REQ byte-stream requesters. Each lane holds a requester for a burst of up
// to MAX_BURST words, and drives IDLE_SYM whenever it has no valid word.
// Optional feature: define PHY_SCHED_STATS_EN to add the saturating per-lane
// word counters word_cnt_0 / word_cnt_1.
module phy_lane_sched #(
  parameter int                NUM_REQ   = 4,
  parameter int                DATA_W    = 8,
  parameter int                MAX_BURST = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM  = 8'hBC
) (
  input  logic                       clk_f,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [DATA_W-1:0]          data_out_0,
  output logic                       valid_out_0,
  output logic [DATA_W-1:0]          data_out_1,
  output logic                       valid_out_1,
  output logic [$clog2(NUM_REQ)-1:0] grant_0,
  output logic [$clog2(NUM_REQ)-1:0] grant_1,
  output logic                       busy_0,
  output logic                       busy_1
`ifdef PHY_SCHED_STATS_EN
  ,
  output logic [15:0]                word_cnt_0,
  output logic [15:0]                word_cnt_1
`endif
);

  localparam int            GW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} lane_state_e;

  // One-hot mask of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // First eligible requester at or after start (wrapping); MSB flags "found".
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                          input logic [GW-1:0]      start);
    logic [GW:0] res;
    int          idx;
    res = {(GW+1){1'b0}};
    // Walk downward so the closest candidate to start is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (elig[idx]) res = {1'b1, idx[GW-1:0]};
    end
    return res;
  endfunction

  // Index following idx, modulo NUM_REQ.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (idx == LAST_REQ) ? {GW{1'b0}} : idx + GW'(1);
  endfunction

  lane_state_e        state_0_r, state_1_r, state_0_nxt_s, state_1_nxt_s;
  logic [GW-1:0]      grant_0_r, grant_1_r, rr_ptr_r, rr_ptr_nxt_s;
  logic [CW-1:0]      cnt_0_r, cnt_1_r;
  logic [NUM_REQ-1:0] hold_0_s, hold_1_s, elig_0_s, elig_1_s, take_mask_0_s;
  logic [GW:0]        pick_0_s, pick_1_s;
  logic               take_0_s, take_1_s, xfer_0_s, xfer_1_s;
  logic [DATA_W-1:0]  word_0_s, word_1_s;

  assign busy_0  = (state_0_r == ST_BURST);
  assign busy_1  = (state_1_r == ST_BURST);
  assign grant_0 = grant_0_r;
  assign grant_1 = grant_1_r;

  // Arbitration for idle lanes, transfer detection and acks for busy lanes.
  always_comb begin
    hold_0_s      = busy_0 ? onehot(grant_0_r) : {NUM_REQ{1'b0}};
    hold_1_s      = busy_1 ? onehot(grant_1_r) : {NUM_REQ{1'b0}};
    // Lane 0 picks first; lane 1 must avoid lane 0's pick of this cycle.
    elig_0_s      = req_valid & ~hold_1_s;
    pick_0_s      = rr_pick(elig_0_s, rr_ptr_r);
    take_0_s      = (state_0_r == ST_IDLE) && pick_0_s[GW];
    take_mask_0_s = take_0_s ? onehot(pick_0_s[GW-1:0]) : {NUM_REQ{1'b0}};
    elig_1_s      = req_valid & ~hold_0_s & ~take_mask_0_s;
    pick_1_s      = rr_pick(elig_1_s, rr_ptr_r);
    take_1_s      = (state_1_r == ST_IDLE) && pick_1_s[GW];

    xfer_0_s = busy_0 && req_valid[grant_0_r];
    xfer_1_s = busy_1 && req_valid[grant_1_r];
    word_0_s = req_data[int'(grant_0_r)*DATA_W +: DATA_W];
    word_1_s = req_data[int'(grant_1_r)*DATA_W +: DATA_W];
    req_ack  = (xfer_0_s ? hold_0_s : {NUM_REQ{1'b0}}) |
               (xfer_1_s ? hold_1_s : {NUM_REQ{1'b0}});

    // Lane 1 counts as the later grant when both lanes grant together.
    if (take_1_s) begin
      rr_ptr_nxt_s = next_idx(pick_1_s[GW-1:0]);
    end else if (take_0_s) begin
      rr_ptr_nxt_s = next_idx(pick_0_s[GW-1:0]);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Next-state logic of both lane FSMs.
  always_comb begin
    state_0_nxt_s = state_0_r;
    state_1_nxt_s = state_1_r;
    case (state_0_r)
      ST_IDLE:  state_0_nxt_s = take_0_s ? ST_BURST : ST_IDLE;
      ST_BURST: state_0_nxt_s = (!xfer_0_s || (cnt_0_r == LAST_CNT)) ? ST_IDLE : ST_BURST;
      default:  state_0_nxt_s = ST_IDLE;
    endcase
    case (state_1_r)
      ST_IDLE:  state_1_nxt_s = take_1_s ? ST_BURST : ST_IDLE;
      ST_BURST: state_1_nxt_s = (!xfer_1_s || (cnt_1_r == LAST_CNT)) ? ST_IDLE : ST_BURST;
      default:  state_1_nxt_s = ST_IDLE;
    endcase
  end

  // Lane FSM state registers.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_0_r <= ST_IDLE;
      state_1_r <= ST_IDLE;
    end else begin
      state_0_r <= state_0_nxt_s;
      state_1_r <= state_1_nxt_s;
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= {GW{1'b0}};
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Lane datapath: grant latch, burst counter and registered lane outputs.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      grant_0_r   <= {GW{1'b0}};
      grant_1_r   <= {GW{1'b0}};
      cnt_0_r     <= {CW{1'b0}};
      cnt_1_r     <= {CW{1'b0}};
      data_out_0  <= IDLE_SYM;
      data_out_1  <= IDLE_SYM;
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
    end else begin
      if (take_0_s) begin
        grant_0_r <= pick_0_s[GW-1:0];
        cnt_0_r   <= {CW{1'b0}};
      end else if (xfer_0_s && (cnt_0_r != LAST_CNT)) begin
        cnt_0_r <= cnt_0_r + CW'(1);
      end
      if (take_1_s) begin
        grant_1_r <= pick_1_s[GW-1:0];
        cnt_1_r   <= {CW{1'b0}};
      end else if (xfer_1_s && (cnt_1_r != LAST_CNT)) begin
        cnt_1_r <= cnt_1_r + CW'(1);
      end
      valid_out_0 <= xfer_0_s;
      valid_out_1 <= xfer_1_s;
      data_out_0  <= xfer_0_s ? word_0_s : IDLE_SYM;
      data_out_1  <= xfer_1_s ? word_1_s : IDLE_SYM;
    end
  end

`ifdef PHY_SCHED_STATS_EN
  // Saturating count of valid words sent on each lane.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      word_cnt_0 <= 16'h0000;
      word_cnt_1 <= 16'h0000;
    end else begin
      if (xfer_0_s && (word_cnt_0 != 16'hFFFF)) word_cnt_0 <= word_cnt_0 + 16'h0001;
      if (xfer_1_s && (word_cnt_1 != 16'hFFFF)) word_cnt_1 <= word_cnt_1 + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_phy_lane_sched.sv
// Self-checking bench for phy_lane_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural lane model.
module tb_phy_lane_sched;

  localparam int         N    = 4;
  localparam int         MB   = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic        clk_f     = 1'b0;
  logic        reset     = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data  = 32'h0000_0000;
  logic [3:0]  req_ack;
  logic [7:0]  data_out_0, data_out_1;
  logic        valid_out_0, valid_out_1;
  logic [1:0]  grant_0, grant_1;
  logic        busy_0, busy_1;
`ifdef PHY_SCHED_STATS_EN
  logic [15:0] word_cnt_0, word_cnt_1;
`endif

  int n_chk = 0;
  int n_err = 0;

  phy_lane_sched dut (
    .clk_f(clk_f), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .data_out_0(data_out_0), .valid_out_0(valid_out_0),
    .data_out_1(data_out_1), .valid_out_1(valid_out_1), .grant_0(grant_0),
    .grant_1(grant_1), .busy_0(busy_0), .busy_1(busy_1)
`ifdef PHY_SCHED_STATS_EN
    , .word_cnt_0(word_cnt_0), .word_cnt_1(word_cnt_1)
`endif
  );

  always #5 clk_f = ~clk_f;

  // Behavioural model: per lane, who holds it and how many words remain.
  int         m_busy[2], m_hold[2], m_left[2], m_wc[2], m_rr;
  logic       m_vout[2];
  logic [7:0] m_dout[2];
  logic [3:0] m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 0; m_hold[l] = 0; m_left[l] = 0; m_wc[l] = 0;
      m_vout[l] = 1'b0; m_dout[l] = IDLE;
    end
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input logic [3:0] v, input logic [31:0] d);
    int   pick[2];
    logic xf[2];
    m_ack = 4'b0000;
    for (int l = 0; l < 2; l++) begin
      xf[l] = (m_busy[l] != 0) && v[m_hold[l]];
      if (xf[l]) m_ack[m_hold[l]] = 1'b1;
    end
    pick[0] = -1;
    pick[1] = -1;
    for (int l = 0; l < 2; l++) begin
      if (m_busy[l] == 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (pick[l] < 0 && v[i] && !(m_busy[1-l] != 0 && m_hold[1-l] == i)
              && !(l == 1 && pick[0] == i))
            pick[l] = i;
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      m_vout[l] = 1'b0;
      m_dout[l] = IDLE;
      if (m_busy[l] != 0) begin
        if (xf[l]) begin
          m_vout[l] = 1'b1;
          m_dout[l] = d[m_hold[l]*8 +: 8];
          m_left[l]--;
          if (m_wc[l] < 65535) m_wc[l]++;
          if (m_left[l] == 0) m_busy[l] = 0;
        end else begin
          m_busy[l] = 0;
        end
      end else if (pick[l] >= 0) begin
        m_busy[l] = 1; m_hold[l] = pick[l]; m_left[l] = MB;
      end
    end
    if (pick[1] >= 0) m_rr = (pick[1] + 1) % N;
    else if (pick[0] >= 0) m_rr = (pick[0] + 1) % N;
  endtask

  // Apply inputs, step the model, and compare the combinational ack.
  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
    model_step(v, d);
    #1;
    chk("req_ack", {28'h0, req_ack}, {28'h0, m_ack});
  endtask

  // Clock edge, then compare all registered outputs with the model.
  task automatic settle();
    @(posedge clk_f);
    #1;
    chk("valid_out_0", {31'h0, valid_out_0}, {31'h0, m_vout[0]});
    chk("data_out_0", {24'h0, data_out_0}, {24'h0, m_dout[0]});
    chk("valid_out_1", {31'h0, valid_out_1}, {31'h0, m_vout[1]});
    chk("data_out_1", {24'h0, data_out_1}, {24'h0, m_dout[1]});
    chk("busy_0", {31'h0, busy_0}, m_busy[0]);
    chk("busy_1", {31'h0, busy_1}, m_busy[1]);
    if (m_busy[0] != 0) chk("grant_0", {30'h0, grant_0}, m_hold[0]);
    if (m_busy[1] != 0) chk("grant_1", {30'h0, grant_1}, m_hold[1]);
`ifdef PHY_SCHED_STATS_EN
    chk("word_cnt_0", {16'h0, word_cnt_0}, m_wc[0]);
    chk("word_cnt_1", {16'h0, word_cnt_1}, m_wc[1]);
`endif
  endtask

  task automatic run_cycle(input logic [3:0] v, input logic [31:0] d);
    drive(v, d);
    settle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid0"}, {31'h0, valid_out_0}, 32'h0);
    chk({tag, "_valid1"}, {31'h0, valid_out_1}, 32'h0);
    chk({tag, "_data0"}, {24'h0, data_out_0}, 32'hBC);
    chk({tag, "_data1"}, {24'h0, data_out_1}, 32'hBC);
    chk({tag, "_ack"}, {28'h0, req_ack}, 32'h0);
    chk({tag, "_busy"}, {30'h0, busy_1, busy_0}, 32'h0);
`ifdef PHY_SCHED_STATS_EN
    chk({tag, "_wcnt"}, {word_cnt_1, word_cnt_0}, 32'h0);
`endif
  endtask

  // Reset with random requests present; release away from the clock edge.
  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 4'($urandom);
    req_data  = $urandom;
    #2;
    check_reset_values("t1_reset");
    @(posedge clk_f);
    #1;
    check_reset_values("t1_reset_edge");
    reset = 1'b1;
    model_reset();
  endtask

  logic [7:0] t2_word [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] t2_data [7] = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBC, 8'h55};
  logic       t2_vld  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int         sent;
    logic [3:0] v;
    model_reset();
    #1;

    // T1/T2: single stream on requester 0.
    do_reset();
    sent = 0;
    for (int c = 0; c < 7; c++) begin
      v = (sent < 5) ? 4'b0001 : 4'b0000;
      drive(v, {24'h0, t2_word[(sent < 5) ? sent : 0]});
      if (m_ack[0]) sent++;
      settle();
      chk("t2_lane0_data", {24'h0, data_out_0}, {24'h0, t2_data[c]});
      chk("t2_lane0_valid", {31'h0, valid_out_0}, {31'h0, t2_vld[c]});
      chk("t2_lane1_idle", {23'h0, valid_out_1, data_out_1}, 32'h0BC);
    end

    // T3: two streams granted together; rr_ptr lands on 3.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      run_cycle((c < 5) ? 4'b0101 : 4'b1111, $urandom);
      if (c == 0) begin
        chk("t3_grants", {28'h0, grant_1, grant_0}, {28'h0, 2'd2, 2'd0});
        chk("t3_busy", {30'h0, busy_1, busy_0}, 32'h3);
      end else if (c < 5) begin
        chk("t3_parallel", {30'h0, valid_out_1, valid_out_0}, 32'h3);
      end else begin
        chk("t3_rr_from3", {28'h0, grant_1, grant_0}, {28'h0, 2'd0, 2'd3});
      end
    end

    // T4: fairness with all requesters valid.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      run_cycle(4'b1111, $urandom);
      chk("t4_lane0_valid", {31'h0, valid_out_0}, (c % 5 != 0) ? 32'h1 : 32'h0);
      if (c == 0 || c == 10) chk("t4_grants01", {28'h0, grant_1, grant_0}, {28'h0, 2'd1, 2'd0});
      if (c == 5) chk("t4_grants23", {28'h0, grant_1, grant_0}, {28'h0, 2'd3, 2'd2});
    end

    // T5: requester 1 drops valid after two acks.
    do_reset();
    for (int c = 0; c < 3; c++) run_cycle(4'b0010, 32'h0000_7700 + 32'(c) * 32'h100);
    chk("t5_second_word", {23'h0, valid_out_0, data_out_0}, 32'h179);
    drive(4'b0000, 32'h0000_7A00);
    chk("t5_no_ack", {28'h0, req_ack}, 32'h0);
    settle();
    chk("t5_bubble", {23'h0, valid_out_0, data_out_0}, 32'h0BC);
    chk("t5_lane_idle", {31'h0, busy_0}, 32'h0);

    // T6: asynchronous reset in the ack cycle of the third word.
    do_reset();
    for (int c = 0; c < 3; c++) run_cycle(4'b0001, {24'h0, 8'hA0 + 8'(c)});
    drive(4'b0001, 32'h0000_00A3);
    chk("t6_third_ack", {28'h0, req_ack}, 32'h1);
    chk("t6_pre_reset", {23'h0, valid_out_0, data_out_0}, 32'h1A2);
    reset = 1'b0;
    #1;
    check_reset_values("t6_async");
    @(posedge clk_f);
    #1;
    reset = 1'b1;
    model_reset();
    run_cycle(4'b1001, $urandom);
    chk("t6_rr_restart", {28'h0, grant_1, grant_0}, {28'h0, 2'd3, 2'd0});

    // Randomized traffic with periodic resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 500 == 499) do_reset();
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
      run_cycle(v, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
